// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, default parameters and key-index helper for the
// matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned DEF_ROWS         = 4;
  localparam int unsigned DEF_COLS         = 4;
  localparam int unsigned DEF_SETTLE_CYC   = 2;
  localparam int unsigned DEF_DEBOUNCE_CYC = 10;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } scan_state_t;

  // Raw key index as seen by the downstream decoder.
  function automatic int unsigned key_index(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo: synchronous first-word-fall-through FIFO.
// Ports: clk, RST (sync, active-high), push/din write side, pop read side,
//        dout (registered head, holds last value when empty), full, empty, count.
module key_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_n_c;
  logic [CNT_W-1:0] count_n_c;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic             head_from_din_c;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  always_comb begin
    pop_ok_c        = pop && !empty;
    push_ok_c       = push && (!full || pop_ok_c);
    rd_ptr_n_c      = pop_ok_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n_c       = count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    // The pushed word becomes the head when nothing else remains.
    head_from_din_c = push_ok_c && (count == CNT_W'(pop_ok_c));
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= din;
  end

  // Pointers, flags and registered head.
  always_ff @(posedge clk) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_n_c;
      count  <= count_n_c;
      full   <= (count_n_c == CNT_W'(DEPTH));
      empty  <= (count_n_c == '0);
      if (count_n_c != '0) dout <= head_from_din_c ? din : mem[rd_ptr_n_c];
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans an active-low ROWS x COLS matrix, debounces press and
// release, rejects chords and queues accepted key indices in a FWFT FIFO.
// Ports: clk, RST (sync, active-high), RowIn (rows, low = contact),
//        ColOut (one-cold column drive), KeyRdy/KeyRd pop handshake,
//        key_code (FIFO head), key_count (occupancy), overflow (sticky drop).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned COLS         = DEF_COLS,
  parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic [ROWS-1:0]               RowIn,
  output logic [COLS-1:0]               ColOut,
  output logic                          KeyRdy,
  input  logic                          KeyRd,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic [$clog2(FIFO_DEPTH):0]   key_count,
  output logic                          overflow
);

  localparam int unsigned CODE_W = $clog2(ROWS * COLS);
  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int unsigned DEB_W  = 8;
  localparam int unsigned LCNT_W = $clog2(ROWS + 1);

  scan_state_t       state_q;
  logic [COL_W-1:0]  col_q;
  logic [SET_W-1:0]  settle_q;
  logic [DEB_W-1:0]  deb_q;
  logic [ROWS-1:0]   pattern_q;

  logic              all_high_c;
  logic [LCNT_W-1:0] low_cnt_c;
  logic [ROW_W-1:0]  low_row_c;
  logic              sample_c;
  logic [DEB_W-1:0]  deb_inc_c;
  logic              decide_c;
  logic              push_c;
  logic [CODE_W-1:0] key_c;
  logic [COL_W-1:0]  col_next_c;
  logic [COLS-1:0]   col_out_next_c;
  logic              fifo_full;
  logic              fifo_empty;

  // Row analysis, debounce decision and the key to push this edge.
  always_comb begin
    all_high_c = &RowIn;
    low_cnt_c  = '0;
    low_row_c  = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (!RowIn[r]) begin
        low_cnt_c = low_cnt_c + LCNT_W'(1);
        low_row_c = ROW_W'(r);
      end
    end
    sample_c   = (settle_q == SET_W'(SETTLE_CYC - 1));
    deb_inc_c  = deb_q + DEB_W'(1);
    // A one-cycle debounce window completes on the sample edge itself.
    decide_c   = ((state_q == SCAN) && sample_c && !all_high_c && (DEBOUNCE_CYC == 1)) ||
                 ((state_q == PRESS) && !all_high_c && (RowIn == pattern_q) &&
                  (deb_inc_c == DEB_W'(DEBOUNCE_CYC)));
    push_c     = decide_c && (low_cnt_c == LCNT_W'(1));
    key_c      = CODE_W'(key_index(32'(low_row_c), 32'(col_q), COLS));
    col_next_c = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
    col_out_next_c = {ColOut[COLS-2:0], ColOut[COLS-1]};
  end

  // Scan / debounce FSM with registered column drive and sticky overflow.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= SCAN;
      col_q     <= '0;
      ColOut    <= ~COLS'(1);
      settle_q  <= '0;
      deb_q     <= '0;
      pattern_q <= '1;
      overflow  <= 1'b0;
    end else begin
      if (push_c && fifo_full && !KeyRd) overflow <= 1'b1;
      case (state_q)
        SCAN: begin
          if (!sample_c) begin
            settle_q <= settle_q + SET_W'(1);
          end else if (all_high_c) begin
            col_q    <= col_next_c;
            ColOut   <= col_out_next_c;
            settle_q <= '0;
          end else if (decide_c) begin
            state_q  <= HELD;
            deb_q    <= '0;
            settle_q <= '0;
          end else begin
            state_q   <= PRESS;
            pattern_q <= RowIn;
            deb_q     <= DEB_W'(1);
            settle_q  <= '0;
          end
        end
        PRESS: begin
          if (all_high_c) begin
            // Contact vanished before debounce completed: treat as glitch.
            state_q  <= SCAN;
            col_q    <= col_next_c;
            ColOut   <= col_out_next_c;
            settle_q <= '0;
            deb_q    <= '0;
          end else if (RowIn != pattern_q) begin
            pattern_q <= RowIn;
            deb_q     <= DEB_W'(1);
          end else if (decide_c) begin
            state_q <= HELD;
            deb_q   <= '0;
          end else begin
            deb_q <= deb_inc_c;
          end
        end
        HELD: begin
          if (!all_high_c) begin
            deb_q <= '0;
          end else if (deb_inc_c == DEB_W'(DEBOUNCE_CYC)) begin
            state_q  <= SCAN;
            col_q    <= col_next_c;
            ColOut   <= col_out_next_c;
            settle_q <= '0;
            deb_q    <= '0;
          end else begin
            deb_q <= deb_inc_c;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  key_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RST   (RST),
    .push  (push_c),
    .din   (key_c),
    .pop   (KeyRd),
    .dout  (key_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (key_count)
  );

  assign KeyRdy = ~fifo_empty;

endmodule
